conv_maxpool: RTL
=================

Name: conv_maxpool

Overview:
- Downstream stage of the 3x3 convolution engine. Consumes its signed 16-bit feature-map stream: 26x26, raster order, one pixel per valid cycle.
- Performs 2x2 stride-2 max pooling, producing a 13x13 pooled map in raster order.
- Holds one row of partial maxima in an internal line buffer, so no frame storage is needed.

Parameters:
- IMG_W, 26, input feature-map width in pixels; must be even.
- IMG_H, 26, input feature-map height in pixels; must be even.
- DATA_W, 16, signed pixel width, input and output.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- pixel_in  input  DATA_W  signed convolution output pixel.
- pixel_valid  input  1  pixel_in is valid this cycle; consumed unconditionally (no backpressure).
- pool_out  output  DATA_W  signed pooled pixel.
- pool_valid  output  1  one-cycle strobe, pool_out valid.
- frame_done  output  1  one-cycle strobe coincident with the last pool_valid of a frame.
- pool_col  output  clog2(IMG_W/2)  column index of pool_out.
- pool_row  output  clog2(IMG_H/2)  row index of pool_out.

Behaviour:
- Reset: when rst=1 at a clk edge, the following are cleared to 0: pool_out, pool_valid, frame_done, pool_col, pool_row, col/row counters and the horizontal-max register. Line buffer contents are not cleared; every entry is always written before it is read. Reset mid-frame abandons the frame and the next valid pixel is treated as (row 0, col 0).
- Counters: col (0..IMG_W-1) and row (0..IMG_H-1) advance only on pixel_valid. col wraps to 0 and increments row; after (IMG_H-1, IMG_W-1) both wrap to 0. Gaps in pixel_valid are allowed; the block holds state across them.
- Even col: h_max <= pixel_in.
- Odd col: m = signed max(h_max, pixel_in).
  - Even row: line_buf[col>>1] <= m. No output.
  - Odd row: on the next edge, pool_out <= signed max(line_buf[col>>1], m), pool_valid <= 1, pool_col <= col>>1, pool_row <= row>>1.
- Latency: exactly 1 cycle from the clk edge accepting the bottom-right pixel of a 2x2 window to pool_valid=1.
- pool_valid is high for exactly one cycle per window, i.e. IMG_W*IMG_H/4 = 169 strobes per 26x26 frame.
- frame_done = 1 in the same cycle as the pool_valid for window (IMG_H/2-1, IMG_W/2-1); otherwise 0.
- Comparisons are two's-complement signed. Ties yield the common value. No width growth, no saturation.
- Between strobes, pool_out holds its last value and pool_col/pool_row hold their last index.
- Line buffer: IMG_W/2 entries of DATA_W bits, one write port and one read port, addressed by col>>1.
- Back-to-back frames with no idle cycles are supported; frame N+1 row 0 overwrites line_buf safely.

Optional Feature:
- Macro CONV_MAXPOOL_RELU_EN.
- Defined: the final pooled value is clamped, pool_out <= (max < 0) ? 0 : max. Timing and strobes are unchanged.
- Undefined: pool_out is the raw signed max; negative values pass through.

Test Plan:
- Reset then a 26x26 frame with pixel = row*26+col, continuous valid -> 169 strobes; first pool_out=27 at (0,0); last pool_out=675 at (12,12) with frame_done=1.
- Window values 5, -3, 7, 2 (top-left, top-right, bottom-left, bottom-right) -> pool_out=7 exactly 1 cycle after the bottom-right pixel is accepted.
- All pixels -100 (i.e. 16'hFF9C) -> without the macro all 169 outputs are -100; with CONV_MAXPOOL_RELU_EN all outputs are 0.
- Same frame as the first scenario with pixel_valid toggled 1,0,1,0 -> identical output values and indices; strobe count 169; no strobe during idle cycles.
- rst asserted after 300 pixels, then a full frame -> no strobes while rst=1; the next frame yields 169 correct outputs starting at (0,0).
- Two frames back-to-back, the second being the negated first -> the second frame's outputs equal the max of the negated values; frame_done pulses exactly twice.

Source files
------------

// File: rtl/conv_maxpool.sv
// conv_maxpool: 2x2 stride-2 max pooling on a raster-order signed pixel stream.
// One row of partial (horizontal-pair) maxima is kept in a small line buffer,
// so the block needs no frame storage.
// Optional feature macro: CONV_MAXPOOL_RELU_EN -- when defined, negative pooled
// results are clamped to zero before they reach pool_out.
module conv_maxpool #(
    parameter int IMG_W  = 26,
    parameter int IMG_H  = 26,
    parameter int DATA_W = 16,
    localparam int PCOL_W = ((IMG_W / 2) > 1) ? $clog2(IMG_W / 2) : 1,
    localparam int PROW_W = ((IMG_H / 2) > 1) ? $clog2(IMG_H / 2) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] pixel_in,
    input  logic                     pixel_valid,
    output logic signed [DATA_W-1:0] pool_out,
    output logic                     pool_valid,
    output logic                     frame_done,
    output logic [PCOL_W-1:0]        pool_col,
    output logic [PROW_W-1:0]        pool_row
);

    localparam int COL_W    = $clog2(IMG_W);
    localparam int ROW_W    = $clog2(IMG_H);
    localparam int LB_DEPTH = IMG_W / 2;

    // Raster position of the pixel currently presented on pixel_in
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    // Left pixel of the current horizontal pair
    logic signed [DATA_W-1:0] h_max_q, h_max_d;

    // Registered outputs
    logic signed [DATA_W-1:0] pool_out_q, pool_out_d;
    logic                     pool_valid_q, pool_valid_d;
    logic                     frame_done_q, frame_done_d;
    logic [PCOL_W-1:0]        pool_col_q, pool_col_d;
    logic [PROW_W-1:0]        pool_row_q, pool_row_d;

    // Line buffer of horizontal-pair maxima from the even row of each band
    logic signed [DATA_W-1:0] line_buf [LB_DEPTH];
    logic [PCOL_W-1:0]        lb_addr;
    logic                     lb_we;
    logic signed [DATA_W-1:0] lb_rdata;

    // Datapath intermediates
    logic signed [DATA_W-1:0] pair_max;
    logic signed [DATA_W-1:0] quad_max;
    logic signed [DATA_W-1:0] pooled;
    logic                     last_pixel;

    assign lb_addr  = PCOL_W'(col_q >> 1);
    assign lb_rdata = line_buf[lb_addr];

    // Max of the horizontal pair, then of the full 2x2 window, plus optional clamp
    always_comb begin
        pair_max = (pixel_in > h_max_q) ? pixel_in : h_max_q;
        quad_max = (lb_rdata > pair_max) ? lb_rdata : pair_max;
`ifdef CONV_MAXPOOL_RELU_EN
        pooled = quad_max[DATA_W-1] ? '0 : quad_max;
`else
        pooled = quad_max;
`endif
        last_pixel = (col_q == COL_W'(IMG_W - 1)) && (row_q == ROW_W'(IMG_H - 1));
    end

    // Next-state logic: counters, pair register, line-buffer write and output strobe
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        h_max_d      = h_max_q;
        pool_out_d   = pool_out_q;
        pool_valid_d = 1'b0;
        frame_done_d = 1'b0;
        pool_col_d   = pool_col_q;
        pool_row_d   = pool_row_q;
        lb_we        = 1'b0;

        if (pixel_valid) begin
            if (!col_q[0]) begin
                h_max_d = pixel_in;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                pool_out_d   = pooled;
                pool_valid_d = 1'b1;
                pool_col_d   = lb_addr;
                pool_row_d   = PROW_W'(row_q >> 1);
                frame_done_d = last_pixel;
            end

            if (col_q == COL_W'(IMG_W - 1)) begin
                col_d = '0;
                if (row_q == ROW_W'(IMG_H - 1)) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            h_max_q      <= '0;
            pool_out_q   <= '0;
            pool_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            pool_col_q   <= '0;
            pool_row_q   <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            h_max_q      <= h_max_d;
            pool_out_q   <= pool_out_d;
            pool_valid_q <= pool_valid_d;
            frame_done_q <= frame_done_d;
            pool_col_q   <= pool_col_d;
            pool_row_q   <= pool_row_d;
        end
    end

    // Line buffer write port; every entry is written on an even row before the odd row reads it
    always_ff @(posedge clk) begin
        if (lb_we) begin
            line_buf[lb_addr] <= pair_max;
        end
    end

    assign pool_out   = pool_out_q;
    assign pool_valid = pool_valid_q;
    assign frame_done = frame_done_q;
    assign pool_col   = pool_col_q;
    assign pool_row   = pool_row_q;

endmodule
